bcd_updown_counter_n: RTL and testbench
=======================================

Name: bcd_updown_counter_n

Overview:
Parametrised multi-digit BCD counter, the successor to the single-digit BCD down counter.
- Counts up or down, selected at run time.
- Supports synchronous parallel load, count enable, and either wrap or saturate at the ends of the range.
- Provides a terminal-count output so that several instances can be cascaded.
- Used as a timer or event counter that drives seven-segment display logic in lab designs.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); range is 0 to 10^DIGITS-1.
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.
- RST_VAL, 0, reset value as a packed BCD constant; each nibble must be 0..9.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  packed BCD load value; digit 0 is in bits [3:0].
- q  output  4*DIGITS  packed BCD count, registered.
- tc  output  1  terminal count, combinational: en & ((up & q==all-9) | (~up & q==0)).
- zero  output  1  combinational flag: q == 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset: when rst=1 at a clk edge, q <= RST_VAL. tc and zero follow from q and en.
- Priority per edge is rst > load > en. When none is active, q holds.
- Load: q <= load_val on the same edge, so the new value is visible one cycle later.
  - Any load_val nibble greater than 9 is clamped to 9 in that digit only; other digits load unchanged.
  - Load ignores en and up.
- Counting: q changes on the edge after en is sampled high, i.e. latency 1.
- Per-digit rule, up: a digit increments when all lower digits are 9. A digit at 9 that increments becomes 0.
- Per-digit rule, down: a digit decrements when all lower digits are 0. A digit at 0 that decrements becomes 9.
- Upper boundary, counting up from all-9:
  - SATURATE=0: wrap to all-0.
  - SATURATE=1: q holds at all-9.
- Lower boundary, counting down from all-0:
  - SATURATE=0: wrap to all-9.
  - SATURATE=1: q holds at all-0.
- tc is asserted at the boundary in both modes, so a downstream stage with en=tc steps exactly once per wrap.
- Direction change takes effect on the next enabled edge. No extra latency and no glitch in q.
- Simultaneous load and en: load wins and no count step is applied.
- Reset mid-count or mid-load: reset wins unconditionally.
- The internal state is only the registered q. No hidden state, so every q value is reachable through load.
- The design never produces an invalid BCD digit, including after any load.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MAX = 4'd9 and BCD_MIN = 4'd0 constants.
  - bcd_digit_t typedef (logic [3:0]).
  - Function bcd_clamp(nibble) returning min(nibble, 9).
- Sub-module bcd_digit_cell, one per digit, generated DIGITS times.
  - Inputs: clk, rst, rst_val, load, load_digit, step, up, sat_hold.
  - Outputs: digit, is_max, is_min.
  - step comes from a ripple chain: step[i] = en & AND of is_max (up) or is_min (down) over all lower digits.
  - sat_hold is driven by top-level logic when SATURATE=1 and the whole counter is at the active boundary.

Test Plan (DIGITS=2 unless noted):
- rst=1 for 2 cycles, then rst=0, en=0 for 5 cycles -> q=8'h00, zero=1, tc=0 throughout.
- en=1, up=1 for 100 edges from 00 -> q steps 00..99 then wraps to 00. tc=1 only while q=99. Nibbles never exceed 9; 09 -> 10 and 59 -> 60 are checked.
- load_val=8'h05, load=1 for 1 cycle, then en=1, up=0 -> q=05,04,..,00,99,98. tc=1 only at q=00.
- SATURATE=1, load 8'h97, en=1, up=1 for 5 edges -> q=98,99,99,99,99 with tc=1 while at 99. Then up=0 for one edge -> q=98.
- load_val=8'hFA with load=1 and en=1 on the same edge -> q=8'h99, no count step applied. Then rst=1 together with load=1 -> q=RST_VAL.
- Cascade: two DIGITS=1 instances, second with en=first.tc, up=1, 25 edges from 0 -> combined value = 25; up=0 for 26 edges -> value 99 (wrapped).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, range constants and the clamp used on loaded or reset nibbles.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic bcd_digit_t bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: reset/load/step with wrap inside the digit; range-end holding comes from sat_hold.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rst_val,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       step,
    input  logic       up,
    input  logic       sat_hold,
    output logic [3:0] digit,
    output logic       is_max,
    output logic       is_min
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_digit);
        end else if (step && !sat_hold) begin
            if (up) begin
                digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    // Reset value is clamped too, so no path can ever hold a non-BCD nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= bcd_clamp(rst_val);
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign is_max = (digit_q == BCD_MAX);
    assign is_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with load, enable, wrap or saturate, and cascadable terminal count.
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned            DIGITS   = 2,
    parameter int unsigned            SATURATE = 0,
    parameter logic [4*DIGITS-1:0]    RST_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  zero
);

    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] is_max;
    logic [DIGITS-1:0] is_min;
    logic              at_max;
    logic              at_min;
    logic              sat_hold;
    logic              chain;

    // Ripple enable: a digit steps when every lower digit sits at the end it is moving toward.
    always_comb begin
        step  = '0;
        chain = en;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            step[i] = chain;
            chain   = chain & (up ? is_max[i] : is_min[i]);
        end
    end

    assign at_max   = &is_max;
    assign at_min   = &is_min;
    assign tc       = en & ((up & at_max) | (~up & at_min));
    assign zero     = at_min;
    assign sat_hold = (SATURATE != 0) && tc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_digit (
            .clk        (clk),
            .rst        (rst),
            .rst_val    (RST_VAL[4*g +: 4]),
            .load       (load),
            .load_digit (load_val[4*g +: 4]),
            .step       (step[g]),
            .up         (up),
            .sat_hold   (sat_hold),
            .digit      (q[4*g +: 4]),
            .is_max     (is_max[g]),
            .is_min     (is_min[g])
        );
    end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench: wrap and saturate 2-digit instances plus a cascade of two 1-digit instances.
module tb_bcd_updown_counter_n;

    localparam logic [7:0] S_RST = 8'h42;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [7:0] load_val = '0;
    logic       c_rst = 1'b1, c_en = 1'b0, c_up = 1'b1;

    logic       n_rst = 1'b1, n_en = 1'b0, n_up = 1'b1, n_load = 1'b0;
    logic [7:0] n_load_val = '0;
    logic       n_c_rst = 1'b1, n_c_en = 1'b0, n_c_up = 1'b1;

    logic [7:0] w_q, s_q;
    logic       w_tc, w_zero, s_tc, s_zero;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_zero, hi_tc, hi_zero;

    bcd_updown_counter_n #(.DIGITS(2), .SATURATE(0), .RST_VAL(8'h00)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(w_q), .tc(w_tc), .zero(w_zero)
    );

    bcd_updown_counter_n #(.DIGITS(2), .SATURATE(1), .RST_VAL(S_RST)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(s_q), .tc(s_tc), .zero(s_zero)
    );

    bcd_updown_counter_n #(.DIGITS(1), .SATURATE(0), .RST_VAL(4'h0)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(1'b0), .load_val(4'h0),
        .q(lo_q), .tc(lo_tc), .zero(lo_zero)
    );

    bcd_updown_counter_n #(.DIGITS(1), .SATURATE(0), .RST_VAL(4'h0)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .up(c_up), .load(1'b0), .load_val(4'h0),
        .q(hi_q), .tc(hi_tc), .zero(hi_zero)
    );

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       tc;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int w_v = 0, s_v = 0, c_v = 0;
    bit w_ok = 0, s_ok = 0, c_ok = 0;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int clamp_load(input logic [7:0] b);
        int h, l;
        h = (int'(b[7:4]) > 9) ? 9 : int'(b[7:4]);
        l = (int'(b[3:0]) > 9) ? 9 : int'(b[3:0]);
        return h * 10 + l;
    endfunction

    function automatic int model_next(input int v, input bit r, input bit ld, input logic [7:0] lv,
                                      input bit e, input bit u, input bit sat, input int rv);
        if (r) return rv;
        if (ld) return clamp_load(lv);
        if (!e) return v;
        if (u) return (v == 99) ? (sat ? 99 : 0) : v + 1;
        return (v == 0) ? (sat ? 0 : 99) : v - 1;
    endfunction

    function automatic bit model_tc(input int v, input bit e, input bit u);
        return e && (u ? (v == 99) : (v == 0));
    endfunction

    task automatic push(input int id, input int v, input bit e, input bit u);
        exp_t x;
        x.id   = id;
        x.q    = int2bcd(v);
        x.tc   = model_tc(v, e, u);
        x.zero = (v == 0);
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst = n_rst; en = n_en; up = n_up; load = n_load; load_val = n_load_val;
        c_rst = n_c_rst; c_en = n_c_en; c_up = n_c_up;
        if (w_ok) push(0, w_v, en, up);
        if (s_ok) push(1, s_v, en, up);
        if (c_ok) push(2, c_v, c_en, c_up);
        w_v = model_next(w_v, rst, load, load_val, en, up, 1'b0, 0);
        s_v = model_next(s_v, rst, load, load_val, en, up, 1'b1, bcd2int(S_RST));
        c_v = model_next(c_v, c_rst, 1'b0, 8'h00, c_en, c_up, 1'b0, 0);
        w_ok = w_ok | rst;
        s_ok = s_ok | rst;
        c_ok = c_ok | c_rst;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.id)
                0: begin
                    chk("wrap_q", w_q, e.q);
                    chk("wrap_tc", {7'd0, w_tc}, {7'd0, e.tc});
                    chk("wrap_zero", {7'd0, w_zero}, {7'd0, e.zero});
                end
                1: begin
                    chk("sat_q", s_q, e.q);
                    chk("sat_tc", {7'd0, s_tc}, {7'd0, e.tc});
                    chk("sat_zero", {7'd0, s_zero}, {7'd0, e.zero});
                end
                default: begin
                    chk("casc_q", {hi_q, lo_q}, e.q);
                    chk("casc_tc", {7'd0, hi_tc}, {7'd0, e.tc});
                    chk("casc_zero", {7'd0, lo_zero & hi_zero}, {7'd0, e.zero});
                end
            endcase
        end
    end

    task automatic set_main(input bit r, input bit ld, input logic [7:0] lv, input bit e, input bit u);
        n_rst = r; n_load = ld; n_load_val = lv; n_en = e; n_up = u;
    endtask

    initial begin
        // Reset both sides for two cycles, then idle.
        set_main(1, 0, 8'h00, 0, 1);
        n_c_rst = 1; n_c_en = 0; n_c_up = 1;
        repeat (2) tick();
        set_main(0, 0, 8'h00, 0, 1);
        n_c_rst = 0;
        repeat (5) tick();

        // Full up-count scan and wrap.
        set_main(0, 0, 8'h00, 1, 1);
        repeat (101) tick();

        // Load 05 then count down through zero.
        set_main(0, 1, 8'h05, 0, 1);
        tick();
        set_main(0, 0, 8'h00, 1, 0);
        repeat (8) tick();

        // Load 97, count up into the top, then reverse once.
        set_main(0, 1, 8'h97, 1, 0);
        tick();
        set_main(0, 0, 8'h00, 1, 1);
        repeat (5) tick();
        set_main(0, 0, 8'h00, 1, 0);
        tick();
        set_main(0, 0, 8'h00, 0, 0);
        tick();

        // Clamped load beats enable; reset beats load.
        set_main(0, 1, 8'hFA, 1, 1);
        tick();
        set_main(0, 0, 8'h00, 0, 1);
        tick();
        set_main(0, 1, 8'h3F, 0, 0);
        tick();
        set_main(1, 1, 8'h77, 1, 1);
        tick();
        set_main(0, 0, 8'h00, 0, 1);
        tick();

        // Cascade of two single-digit stages.
        n_c_rst = 1; tick();
        n_c_rst = 0; n_c_en = 1; n_c_up = 1;
        repeat (25) tick();
        n_c_up = 0;
        repeat (26) tick();
        n_c_en = 0;
        tick();

        // Randomized traffic on every instance.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] lv;
            lv = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0: lv = 8'h00;
                    1: lv = 8'h99;
                    2: lv = 8'h98;
                    default: lv = 8'h01;
                endcase
            end
            set_main($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, lv,
                     $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            n_c_rst = ($urandom_range(0, 63) == 0);
            n_c_en  = ($urandom_range(0, 3) != 0);
            n_c_up  = 1'($urandom_range(0, 1));
            tick();
        end

        set_main(0, 0, 8'h00, 0, 1);
        n_c_en = 0;
        tick();
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
